// File: rtl/uart_pkg.sv
// Shared constants for the UART echo transmitter: FSM encoding, frame shape
// and baud divider derivation.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  // Clock cycles per bit, truncating.
  function automatic int unsigned bps_div(input int unsigned clk_freq,
                                          input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Small byte queue between the receiver capture and the transmitter.
// A push into a full queue is kept only when a pop happens on the same edge.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_BITS-1:0] wdata,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 empty,
  output logic                 full,
  output logic                 overflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_q;
  logic [AW-1:0]        rd_q;
  logic [AW:0]          cnt_q;
  logic [AW:0]          cnt_d;
  logic                 wr_en;
  logic                 rd_en;
  logic                 empty_q;
  logic                 full_q;
  logic                 overflow_q;

  always_comb begin
    rd_en = pop & (cnt_q != '0);
    wr_en = push & ((cnt_q != FULL_CNT) | rd_en);
    cnt_d = cnt_q;
    if (wr_en & ~rd_en) begin
      cnt_d = cnt_q + 1'b1;
    end else if (rd_en & ~wr_en) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_q] <= wdata;
    end
  end

  // Flags are registered from the post-edge count so they track the queue exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (rd_en) rd_q <= rd_q + 1'b1;
      cnt_q      <= cnt_d;
      empty_q    <= (cnt_d == '0);
      full_q     <= (cnt_d == FULL_CNT);
      overflow_q <= push & ~wr_en;
    end
  end

  assign rdata    = mem_q[rd_q];
  assign empty    = empty_q;
  assign full     = full_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_echo.sv
// Echo transmitter: captures each byte completed by the UART receiver and
// replays queued bytes as 8N1 frames with an internally generated baud rate.
module uart_tx_echo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_int,
  input  logic [7:0] data_in,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int unsigned BPS_DIV  = bps_div(CLK_FREQ, BAUD);
  localparam int unsigned STOP_LEN = BPS_DIV * STOP_BITS;
  localparam int unsigned CW       = (STOP_LEN > 1) ? $clog2(STOP_LEN) : 1;
  localparam logic [CW-1:0] BIT_END  = CW'(BPS_DIV - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_LEN - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rx_int_q;
  logic                 push_c;
  logic                 pop_c;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_empty;

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;

  // Falling edge of the receiver busy flag marks a completed byte.
  assign push_c = rx_int_q & ~rx_int;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_c),
    .pop      (pop_c),
    .wdata    (data_in),
    .rdata    (fifo_rdata),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .overflow (overflow)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_c   = 1'b0;
    tx_d    = 1'b1;
    busy_d  = 1'b0;

    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          shift_d = fifo_rdata;
          bit_d   = '0;
          baud_d  = '0;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (baud_q == BIT_END) begin
          baud_d  = '0;
          state_d = TX_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (baud_q == BIT_END) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) state_d = TX_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (baud_q == STOP_END) begin
          baud_d  = '0;
          state_d = TX_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // Line level follows the next state so it flops on the same edge as the FSM.
    case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != TX_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_int_q <= 1'b0;
      state_q  <= TX_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      rx_int_q <= rx_int;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  assign uart_tx = tx_q;
  assign tx_busy = busy_q;

endmodule
